uart_rx: RTL

- UART receiver; the receive-side counterpart of the team's uart_tx.
- Runs on the 50 MHz system clock that the board PLL produces.
- Deserialises an asynchronous 8N1 serial line into bytes and emits a one-cycle valid strobe per frame.
- Flags framing errors. Consumers are the ROM-demo command/loopback logic.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default clocking, frame width and the receiver/transmitter state encoding.
package uart_pkg;

  localparam int CLK_FREQ_DEF  = 50_000_000;
  localparam int BAUD_RATE_DEF = 115200;
  localparam int DATA_BITS     = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } uart_state_t;

  // Clocks per bit; callers must keep the result >= 16.
  function automatic int baud_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a third flop for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_lvl,
  output logic rx_fall
);

  logic [2:0] sync;

  // Reset to all ones so a line that is idle-high produces no edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], rx};
    end
  end

  assign rx_lvl  = sync[1];
  assign rx_fall = sync[2] & ~sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a baud counter, one-cycle valid / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic       iws_clk_50M,
  input  logic       iws_reset_n,
  input  logic       iws_rx,
  output logic [7:0] ows_data,
  output logic       ows_valid,
  output logic       ows_frame_err,
  output logic       ows_busy
);

  localparam int BAUD_CNT = baud_cnt(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_lvl;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (iws_clk_50M),
    .rst_n   (iws_reset_n),
    .rx      (iws_rx),
    .rx_lvl  (rx_lvl),
    .rx_fall (rx_fall)
  );

  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [7:0]           data_nxt;
  logic                 valid_nxt;
  logic                 err_nxt;

  always_ff @(posedge iws_clk_50M or negedge iws_reset_n) begin
    if (!iws_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      ows_data      <= '0;
      ows_valid     <= 1'b0;
      ows_frame_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      shift         <= shift_nxt;
      ows_data      <= data_nxt;
      ows_valid     <= valid_nxt;
      ows_frame_err <= err_nxt;
    end
  end

  // The counter only runs inside a frame and is zeroed at every sample point.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = ows_data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_fall) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_lvl ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_lvl;
          if (idx == IDX_LAST) state_nxt = STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rx_lvl) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rx_lvl) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign ows_busy = (state != IDLE);

endmodule
